// File: rtl/keypad_pkg.sv
// Shared types, matrix geometry and key-map helpers for the keypad scanner.
package keypad_pkg;

  localparam int KP_ROWS   = 4;
  localparam int KP_COLS   = 4;
  localparam int KP_KEYS   = KP_ROWS * KP_COLS;
  localparam int KP_CODE_W = 4;
  localparam int KP_CNT_W  = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } kp_state_t;

  // Number of keys set in a debounced key map.
  function automatic logic [KP_CNT_W-1:0] kp_popcount(input logic [KP_KEYS-1:0] map);
    logic [KP_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < KP_KEYS; i++) begin
      n = n + {{(KP_CNT_W-1){1'b0}}, map[i]};
    end
    return n;
  endfunction

  // Index of the highest set key; only meaningful when exactly one key is set.
  function automatic logic [KP_CODE_W-1:0] kp_key_index(input logic [KP_KEYS-1:0] map);
    logic [KP_CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KP_KEYS; i++) begin
      if (map[i]) idx = KP_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Free-running divider producing a one-clock tick every DIV clocks.
module scan_tick_gen #(
  parameter int DIV = 100_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick at the terminal count and wrap back to zero.
  always_comb begin
    tick_o = (cnt_q == TERM);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  // Divider counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column synchronizer, whole-frame
// debounce and a press/release FSM that reports each new key once.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int SCAN_HZ         = 1_000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [KP_ROWS-1:0]   keyRow,
  input  logic [KP_COLS-1:0]   keyCol,
  output logic [KP_CODE_W-1:0] keyCode,
  output logic                 keyValid,
  output logic                 keyHeld
);

  localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0] SAT = SW'(DEBOUNCE_FRAMES);
  localparam logic [SW-1:0] PRE = SW'(DEBOUNCE_FRAMES - 2);
  localparam logic [1:0]    LAST_ROW = 2'(KP_ROWS - 1);

  logic                 tick;
  logic [KP_COLS-1:0]   col_s1_q, col_s2_q;
  logic [1:0]           row_q, row_d;
  logic [KP_KEYS-1:0]   cur_frame_q, cur_frame_d, frame_now;
  logic [KP_KEYS-1:0]   prev_frame_q, prev_frame_d;
  logic [KP_KEYS-1:0]   deb_frame_q, deb_frame_d;
  logic [SW-1:0]        stable_cnt_q, stable_cnt_d;
  logic                 deb_upd_q, deb_upd_d;
  kp_state_t            state_q, state_d;
  logic [KP_CODE_W-1:0] code_q, code_d, dec_code;
  logic                 valid_q, valid_d;
  logic [KP_CNT_W-1:0]  dec_ones;
  logic                 dec_single, dec_none;

  scan_tick_gen #(.DIV(CLK_HZ / SCAN_HZ)) u_tick (
    .clk_i  (clk),
    .rst_ni (reset),
    .tick_o (tick)
  );

  assign keyRow = ~(4'b0001 << row_q);

  // Two-flop synchronizer; idle columns read high through the pull-ups.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_s1_q <= '1;
      col_s2_q <= '1;
    end else begin
      col_s1_q <= keyCol;
      col_s2_q <= col_s1_q;
    end
  end

  // Row capture at the end of each row period and frame-level debounce.
  always_comb begin
    frame_now = cur_frame_q;
    frame_now[{row_q, 2'b00} +: KP_COLS] = ~col_s2_q;
    cur_frame_d  = tick ? frame_now : cur_frame_q;
    row_d        = tick ? row_q + 2'd1 : row_q;
    prev_frame_d = prev_frame_q;
    stable_cnt_d = stable_cnt_q;
    deb_frame_d  = deb_frame_q;
    deb_upd_d    = 1'b0;
    if (tick && row_q == LAST_ROW) begin
      prev_frame_d = frame_now;
      if (frame_now == prev_frame_q) begin
        if (stable_cnt_q != SAT) stable_cnt_d = stable_cnt_q + 1'b1;
        // Only the transition into DEBOUNCE_FRAMES-1 publishes a new map.
        if (stable_cnt_q == PRE) begin
          deb_frame_d = frame_now;
          deb_upd_d   = 1'b1;
        end
      end else begin
        stable_cnt_d = '0;
      end
    end
  end

  // Scan and debounce registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q        <= '0;
      cur_frame_q  <= '0;
      prev_frame_q <= '0;
      stable_cnt_q <= '0;
      deb_frame_q  <= '0;
      deb_upd_q    <= 1'b0;
    end else begin
      row_q        <= row_d;
      cur_frame_q  <= cur_frame_d;
      prev_frame_q <= prev_frame_d;
      stable_cnt_q <= stable_cnt_d;
      deb_frame_q  <= deb_frame_d;
      deb_upd_q    <= deb_upd_d;
    end
  end

  // Classify the debounced map; multi-key maps are neither single nor none.
  always_comb begin
    dec_ones   = kp_popcount(deb_frame_q);
    dec_single = (dec_ones == KP_CNT_W'(1));
    dec_none   = (dec_ones == '0);
    dec_code   = kp_key_index(deb_frame_q);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  // FSM next state, advanced only when a debounced map is published.
  always_comb begin
    state_d = state_q;
    if (deb_upd_q) begin
      case (state_q)
        IDLE:    if (dec_single) state_d = PRESSED;
        PRESSED: if (dec_none)   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: report a key only when leaving IDLE on a single press.
  always_comb begin
    valid_d = 1'b0;
    code_d  = code_q;
    keyHeld = (state_q == PRESSED);
    if (deb_upd_q && state_q == IDLE && dec_single) begin
      valid_d = 1'b1;
      code_d  = dec_code;
    end
  end

  assign keyCode  = code_q;
  assign keyValid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: matrix model, frame-level reference model and
// directed scenarios (row walk, single key, bounce, multi-key, rollover, reset).
module tb_keypad_scanner;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 100;
  localparam int DEB     = 4;
  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int FRAME   = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] keyRow, keyCol, keyCode;
  logic       keyValid, keyHeld;
  logic [15:0] pressed = '0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .keyRow(keyRow), .keyCol(keyCol),
    .keyCode(keyCode), .keyValid(keyValid), .keyHeld(keyHeld)
  );

  // Physical matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    keyCol = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!keyRow[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) keyCol[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [3:0] row_pat(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << r);
  endfunction

  // ---------------- reference model ----------------
  int          m_cnt, m_row, m_run;
  logic [3:0]  m_s1, m_s2;
  logic [15:0] m_frame, m_prev, pend_frame;
  bit          pend, m_held;
  logic [3:0]  exp_code;
  bit          exp_valid, exp_held;

  task automatic model_reset();
    m_cnt = 0; m_row = 0; m_run = 1;
    m_s1 = '0; m_s2 = '0;
    m_frame = '0; m_prev = '0; pend_frame = '0;
    pend = 0; m_held = 0;
    exp_code = '0; exp_valid = 0; exp_held = 0;
  endtask

  task automatic model_step();
    logic [3:0] sample;
    int ones;
    sample = pressed[m_row*4 +: 4];
    exp_valid = 0;
    if (pend) begin
      ones = $countones(pend_frame);
      if (!m_held && ones == 1) begin
        m_held = 1;
        exp_valid = 1;
        for (int k = 0; k < 16; k++) if (pend_frame[k]) exp_code = 4'(k);
      end else if (m_held && ones == 0) begin
        m_held = 0;
      end
      pend = 0;
    end
    exp_held = m_held;
    if (m_cnt == DIV - 1) begin
      m_frame[m_row*4 +: 4] = m_s2;
      if (m_row == 3) begin
        if (m_frame == m_prev) begin
          if (m_run < DEB) begin
            m_run++;
            if (m_run == DEB) begin
              pend = 1;
              pend_frame = m_frame;
            end
          end
        end else begin
          m_run = 1;
        end
        m_prev = m_frame;
      end
      m_row = (m_row + 1) % 4;
    end
    m_s2 = m_s1;
    m_s1 = sample;
    m_cnt = (m_cnt + 1) % DIV;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare and pulse monitor ----------------
  int         cyc = 0;
  int         pulses = 0;
  int         last_pulse_cyc = 0;
  logic [3:0] last_code = '0;
  bit         prev_valid = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check($sformatf("outputs@%0d row/code/valid/held", cyc),
            {16'h0, keyRow, keyCode, 3'b0, keyValid, 3'b0, keyHeld},
            {16'h0, row_pat(m_row), exp_code, 3'b0, exp_valid, 3'b0, exp_held});
      if (keyValid) begin
        check($sformatf("valid_gap@%0d", cyc), {31'd0, prev_valid}, 32'd0);
        pulses++;
        last_code = keyCode;
        last_pulse_cyc = cyc;
      end
      prev_valid = keyValid;
    end
  end

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  int         p0, t0;
  int         rw_idx [6] = '{0, 8, 9, 19, 29, 39};
  logic [3:0] rw_exp [6] = '{4'b1110, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_row",   {28'd0, keyRow}, 32'hE);
    check("reset_code",  {28'd0, keyCode}, 32'd0);
    check("reset_valid", {31'd0, keyValid}, 32'd0);
    check("reset_held",  {31'd0, keyHeld}, 32'd0);

    // Row walk with no keys.
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      for (int j = 0; j < 6; j++)
        if (rw_idx[j] == i) check($sformatf("rowwalk_%0d", i), {28'd0, keyRow}, {28'd0, rw_exp[j]});
    end
    wait_frames(4);
    check("rowwalk_no_pulse", pulses, 0);

    // Single key 5.
    p0 = pulses; t0 = cyc;
    pressed = 16'h0020;
    wait_frames(10);
    check("single_pulses", pulses - p0, 1);
    check("single_code", {28'd0, last_code}, 32'd5);
    check("single_held", {31'd0, keyHeld}, 32'd1);
    check("single_latency_ok", {31'd0, (last_pulse_cyc - t0) <= (DEB + 1) * FRAME + 3}, 32'd1);
    pressed = '0;
    wait_frames(6);
    check("single_released", {31'd0, keyHeld}, 32'd0);
    check("single_no_extra", pulses - p0, 1);

    // Bounce on key 14, then stable.
    p0 = pulses;
    for (int k = 0; k < 6; k++) begin
      pressed = pressed ^ 16'h4000;
      repeat (13) @(negedge clk);
    end
    #1;
    check("bounce_no_pulse", pulses - p0, 0);
    pressed = 16'h4000;
    wait_frames(8);
    check("bounce_pulses", pulses - p0, 1);
    check("bounce_code", {28'd0, last_code}, 32'd14);
    pressed = '0;
    wait_frames(6);
    check("bounce_released", {31'd0, keyHeld}, 32'd0);

    // Multi-key 0 + 15.
    p0 = pulses;
    pressed = 16'h8001;
    wait_frames(8);
    check("multi_no_pulse", pulses - p0, 0);
    check("multi_held", {31'd0, keyHeld}, 32'd0);
    pressed = '0;
    wait_frames(6);

    // Rollover 3 -> 9.
    p0 = pulses;
    pressed = 16'h0008;
    wait_frames(6);
    check("roll_first_pulse", pulses - p0, 1);
    check("roll_first_code", {28'd0, keyCode}, 32'd3);
    pressed = 16'h0208;
    wait_frames(2);
    pressed = 16'h0200;
    wait_frames(8);
    check("roll_no_second", pulses - p0, 1);
    check("roll_code_kept", {28'd0, keyCode}, 32'd3);
    check("roll_held", {31'd0, keyHeld}, 32'd1);
    pressed = '0;
    wait_frames(6);
    check("roll_released", {31'd0, keyHeld}, 32'd0);
    pressed = 16'h0200;
    wait_frames(6);
    check("roll_new_pulse", pulses - p0, 2);
    check("roll_new_code", {28'd0, keyCode}, 32'd9);
    pressed = '0;
    wait_frames(6);

    // Reset while key 7 is held and accepted.
    pressed = 16'h0080;
    wait_frames(6);
    check("rst_pre_code", {28'd0, keyCode}, 32'd7);
    check("rst_pre_held", {31'd0, keyHeld}, 32'd1);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("rst_mid_code", {28'd0, keyCode}, 32'd0);
    check("rst_mid_held", {31'd0, keyHeld}, 32'd0);
    check("rst_mid_row", {28'd0, keyRow}, 32'hE);
    check("rst_mid_valid", {31'd0, keyValid}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    p0 = pulses;
    wait_frames(6);
    check("rst_repress_pulses", pulses - p0, 1);
    check("rst_repress_code", {28'd0, keyCode}, 32'd7);
    pressed = '0;
    wait_frames(6);
    check("rst_final_held", {31'd0, keyHeld}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
